// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the HI/LO sequencer: FSM states, divider constants
// and a small magnitude helper used when latching signed divide operands.
package muldiv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  localparam int unsigned DIV_ITER = 32;
  localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;

  // Two's-complement magnitude; 0x8000_0000 maps to itself, which the
  // unsigned divider core treats as 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_sched_div_iter.sv
// Restoring unsigned divider core, one quotient bit per cycle.
// start loads the operands; DIV_ITER steps follow; done is high during the
// cycle whose closing edge performs the last step, so quotient/remainder are
// final from the cycle after done.
module muldiv_sched_div_iter
  import muldiv_sched_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0] dvsr_q;
  logic [4:0]  step_q;
  logic        run_q;
  logic [32:0] partial;
  logic [32:0] trial;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  always_comb begin
    partial = {remainder, quotient[31]};
    trial   = partial - {1'b0, dvsr_q};
  end

  assign done = run_q & (step_q == 5'(DIV_ITER - 1));

  // Operand load on start, then one restoring step per cycle while running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quotient  <= '0;
      remainder <= '0;
      dvsr_q    <= '0;
      step_q    <= '0;
      run_q     <= 1'b0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      dvsr_q    <= divisor;
      step_q    <= '0;
      run_q     <= 1'b1;
    end else if (run_q) begin
      if (!trial[32]) begin
        remainder <= trial[31:0];
        quotient  <= {quotient[30:0], 1'b1};
      end else begin
        remainder <= partial[31:0];
        quotient  <= {quotient[30:0], 1'b0};
      end
      step_q <= step_q + 5'd1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// HI/LO sequencer for the EX stage: fixed-latency multiply, iterative divide,
// MTHI/MTLO writes and MFHI/MFLO reads. Any HI/LO instruction arriving while an
// operation is in flight is stalled, so HI/LO hazards never need forwarding.
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
)
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        issue_valid,
  input  logic [1:0]  mult,
  input  logic [1:0]  div,
  input  logic [1:0]  mfhl,
  input  logic [1:0]  mthl,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] MUL_CNT_INIT = 2'(MUL_LAT - 1);

  state_t      state;
  logic [31:0] hi_q, lo_q;
  logic [31:0] op_a, op_b;
  logic        mul_signed;
  logic [1:0]  mul_cnt;
  logic        q_neg, r_neg, div_zero;

  logic        hl_any, accept, start_div, div_signed;
  logic [31:0] dvd_in, dvs_in;
  logic [63:0] a64, b64, prod;
  logic [31:0] quo, rem;
  logic        div_done;

  assign hl_any     = |{mult, div, mfhl, mthl};
  assign busy       = (state != ST_IDLE);
  assign stall      = issue_valid & hl_any & busy;
  assign accept     = issue_valid & ~stall;
  assign start_div  = (state == ST_IDLE) & accept & (|div);
  assign div_signed = div[0];
  assign hi         = hi_q;
  assign lo         = lo_q;

  // Divider operands: magnitudes for signed divide, raw values for divu.
  always_comb begin
    dvd_in = div_signed ? abs32(rs_data) : rs_data;
    dvs_in = div_signed ? abs32(rt_data) : rt_data;
  end

  // Product from the latched operands; sign extension to 64 bits makes the
  // low 64 bits of the product correct for both mult and multu.
  always_comb begin
    a64  = {{32{mul_signed & op_a[31]}}, op_a};
    b64  = {{32{mul_signed & op_b[31]}}, op_b};
    prod = a64 * b64;
  end

  // MFHI/MFLO read port, zero when no read is requested.
  always_comb begin
    hilo_rdata = '0;
    if (mfhl[1])      hilo_rdata = hi_q;
    else if (mfhl[0]) hilo_rdata = lo_q;
  end

  muldiv_sched_div_iter u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start_div),
    .dividend  (dvd_in),
    .divisor   (dvs_in),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );

  // Sequencer FSM: accepts HI/LO ops in IDLE and owns the HI/LO registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      op_a       <= '0;
      op_b       <= '0;
      mul_signed <= 1'b0;
      mul_cnt    <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (|div) begin
              state    <= ST_DIV;
              op_a     <= rs_data;
              q_neg    <= div_signed & (rs_data[31] ^ rt_data[31]);
              r_neg    <= div_signed & rs_data[31];
              div_zero <= (rt_data == '0);
            end else if (|mult) begin
              state      <= ST_MUL;
              op_a       <= rs_data;
              op_b       <= rt_data;
              mul_signed <= mult[0];
              mul_cnt    <= MUL_CNT_INIT;
            end else begin
              if (mthl[1]) hi_q <= rs_data;
              if (mthl[0]) lo_q <= rs_data;
            end
          end
        end
        ST_MUL: begin
          if (mul_cnt == '0) begin
            hi_q  <= prod[63:32];
            lo_q  <= prod[31:0];
            state <= ST_IDLE;
          end else begin
            mul_cnt <= mul_cnt - 2'd1;
          end
        end
        ST_DIV: begin
          if (div_done) state <= ST_FIX;
        end
        ST_FIX: begin
          if (div_zero) begin
            hi_q <= op_a;
            lo_q <= DIV0_LO;
          end else begin
            lo_q <= q_neg ? (~quo + 32'd1) : quo;
            hi_q <= r_neg ? (~rem + 32'd1) : rem;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: a program-order HI/LO model predicts every
// MFHI/MFLO result; a negedge monitor compares reads as they are accepted.
module tb_muldiv_sched;

  localparam int unsigned MUL_LAT = 3;

  typedef enum int {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
                    OP_MFHI, OP_MFLO, OP_ALU} op_e;

  logic        clk;
  logic        resetn;
  logic        issue_valid;
  logic [1:0]  mult, div, mfhl, mthl;
  logic [31:0] rs_data, rt_data;
  logic        stall, busy;
  logic [31:0] hilo_rdata, hi, lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  muldiv_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .issue_valid (issue_valid),
    .mult        (mult),
    .div         (div),
    .mfhl        (mfhl),
    .mthl        (mthl),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .stall       (stall),
    .busy        (busy),
    .hilo_rdata  (hilo_rdata),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural reference: MIPS-style multiply with 64-bit integers.
  task automatic model_mult(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sp = sa * sb;
      m_hi = sp[63:32];
      m_lo = sp[31:0];
    end else begin
      ua = 64'(a);
      ub = 64'(b);
      up = ua * ub;
      m_hi = up[63:32];
      m_lo = up[31:0];
    end
  endtask

  // Architectural reference: truncating divide, remainder follows dividend.
  task automatic model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) begin
      m_hi = a;
      m_lo = 32'hFFFF_FFFF;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        m_lo = 32'h8000_0000;
        m_hi = 32'd0;
      end else begin
        sa = $signed(a);
        sb = $signed(b);
        m_lo = sa / sb;
        m_hi = sa % sb;
      end
    end else begin
      m_lo = a / b;
      m_hi = a % b;
    end
  endtask

  // Drive one instruction from posedge+1, hold until accepted, return stall count.
  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    logic [1:0] m, d, f, t;
    m = 2'b00; d = 2'b00; f = 2'b00; t = 2'b00;
    case (op)
      OP_MULT:  begin m = 2'b01; model_mult(1'b1, a, b); end
      OP_MULTU: begin m = 2'b10; model_mult(1'b0, a, b); end
      OP_DIV:   begin d = 2'b01; model_div(1'b1, a, b); end
      OP_DIVU:  begin d = 2'b10; model_div(1'b0, a, b); end
      OP_MTHI:  begin t = 2'b10; m_hi = a; end
      OP_MTLO:  begin t = 2'b01; m_lo = a; end
      OP_MFHI:  begin f = 2'b10; exp_q.push_back(m_hi); end
      OP_MFLO:  begin f = 2'b01; exp_q.push_back(m_lo); end
      default:  ;
    endcase
    issue_valid = 1'b1;
    mult = m; div = d; mfhl = f; mthl = t;
    rs_data = a; rt_data = b;
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stall) check("accept_timeout", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    mult = '0; div = '0; mfhl = '0; mthl = '0;
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  // Count cycles with busy high, bounded; returns at posedge+1.
  task automatic measure_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (busy) check("busy_timeout", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted MFHI/MFLO read is compared in order.
  always @(negedge clk) begin
    if (resetn && issue_valid && (mfhl != 2'b00) && !stall) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_read", hilo_rdata, 32'hDEAD_BEEF);
      end else begin
        check("mfhl_read", hilo_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    int   st, n, r;
    op_e  op;
    logic [31:0] a, b;

    resetn = 1'b0;
    issue_valid = 1'b0;
    mult = '0; div = '0; mfhl = '0; mthl = '0;
    rs_data = '0; rt_data = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_rdata", hilo_rdata, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Reset values through the read port, then MTHI/MFHI with no stalls.
    issue(OP_MFHI, 32'd0, 32'd0, st);
    check("mfhi_idle_stall", st, 32'd0);
    issue(OP_MFLO, 32'd0, 32'd0, st);
    issue(OP_MTHI, 32'h1234_5678, 32'd0, st);
    check("mthi_idle_stall", st, 32'd0);
    issue(OP_MFHI, 32'd0, 32'd0, st);
    check("mfhi_after_mthi_stall", st, 32'd0);

    // Signed and unsigned multiply of 0xFFFF_FFFE by 3.
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, st);
    measure_busy(n);
    check("mult_busy_cycles", n, MUL_LAT);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3, st);
    measure_busy(n);
    check("multu_busy_cycles", n, MUL_LAT);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);
    issue(OP_MFHI, 32'd0, 32'd0, st);
    issue(OP_MFLO, 32'd0, 32'd0, st);

    // -7 / 2 with a back-to-back MFLO held for the whole divide.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, st);
    issue(OP_MFLO, 32'd0, 32'd0, st);
    check("div_mflo_stall", st, 32'd33);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    // Divide by zero and signed overflow.
    issue(OP_DIVU, 32'd100, 32'd0, st);
    measure_busy(n);
    check("divu0_busy_cycles", n, 32'd33);
    check("divu0_hi", hi, 32'd100);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
    measure_busy(n);
    check("div_ovf_busy_cycles", n, 32'd33);
    check("div_ovf_hi", hi, 32'd0);
    check("div_ovf_lo", lo, 32'h8000_0000);
    issue(OP_MFHI, 32'd0, 32'd0, st);
    issue(OP_MFLO, 32'd0, 32'd0, st);

    // Non-HI/LO op passes during a divide; MTHI waits and lands after it.
    issue(OP_DIV, 32'd1000, 32'd7, st);
    issue(OP_ALU, 32'd0, 32'd0, st);
    check("alu_during_div_stall", st, 32'd0);
    issue(OP_MTHI, 32'hCAFE_F00D, 32'd0, st);
    check("mthi_during_div_stall", st, 32'd32);
    check("mthi_after_div_hi", hi, 32'hCAFE_F00D);
    check("mthi_after_div_lo", lo, 32'd142);
    issue(OP_MFHI, 32'd0, 32'd0, st);
    issue(OP_MFLO, 32'd0, 32'd0, st);

    // Asynchronous reset part-way through a divide.
    issue(OP_DIV, 32'd12345, 32'd67, st);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    issue(OP_MULT, 32'h0001_0000, 32'h0003_0000, st);
    measure_busy(n);
    check("postrst_mult_busy", n, MUL_LAT);
    check("postrst_mult_hi", hi, 32'd3);
    check("postrst_mult_lo", lo, 32'd0);
    issue(OP_DIVU, 32'd50, 32'd7, st);
    issue(OP_MFLO, 32'd0, 32'd0, st);
    issue(OP_MFHI, 32'd0, 32'd0, st);

    // Randomized instruction stream against the program-order model.
    for (int i = 0; i < 60; i++) begin
      op = op_e'($urandom_range(0, 8));
      a  = $urandom;
      r  = $urandom_range(0, 3);
      case (r)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = $urandom;
        default: b = 32'hFFFF_FFFF;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      issue(op, a, b, st);
      if (op == OP_ALU) check("rand_alu_stall", st, 32'd0);
      if (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} && $urandom_range(0, 1) == 1) begin
        issue(OP_MFHI, 32'd0, 32'd0, st);
        issue(OP_MFLO, 32'd0, 32'd0, st);
      end
    end
    issue(OP_MFHI, 32'd0, 32'd0, st);
    issue(OP_MFLO, 32'd0, 32'd0, st);
    repeat (2) @(posedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
